arf104b256e1r1w0cbbehcaa4acw_port_sched: RTL

- Sequencer/arbiter in front of the 104b x 256-entry 1R1W register file.
- After reset it zero-initialises every entry, then shares the single write port and single read port among NUM_REQ requesters using round-robin arbitration.
- Drives the array's write/read enables; these also serve as the clock-gate enables for the array. Returns tagged read responses.
- Resolves same-address read/write collisions.

---
 rtl/arf104b256e1r1w0cbbehcaa4acw_port_sched_pkg.sv | 45 ++++
 rtl/arf104b256e1r1w0cbbehcaa4acw_rr_arb.sv | 61 ++++++
 rtl/arf104b256e1r1w0cbbehcaa4acw_port_sched.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/arf104b256e1r1w0cbbehcaa4acw_port_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : arf104b256e1r1w0cbbehcaa4acw_port_sched_pkg                   |
// | Purpose  : Shared types and default sizes for the 104b x 256 1R1W        |
// |            register-file port scheduler.                                 |
// | Contents : state_t FSM encoding, default dimensions, response-pipe entry |
// |            struct, one-hot to index helper.                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package arf104b256e1r1w0cbbehcaa4acw_port_sched_pkg;

  localparam int c_num_req = 4;
  localparam int c_addr_w  = 8;
  localparam int c_depth   = 256;
  localparam int c_data_w  = 104;
  localparam int c_rd_lat  = 1;

  // Response-pipe entry fields are sized from the default configuration.
  localparam int c_rsp_id_w = $clog2(c_num_req);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic                  vld;
    logic [c_rsp_id_w-1:0] id;
    logic                  byp;
    logic [c_data_w-1:0]   byp_data;
  } rsp_ent_t;

  // Index of the set bit of a one-hot vector (up to 8 requesters).
  function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arf104b256e1r1w0cbbehcaa4acw_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : arf104b256e1r1w0cbbehcaa4acw_rr_arb                           |
// | Purpose  : Round-robin arbiter. Picks the first request at or after the  |
// |            pointer (wrapping); the pointer moves past the winner only    |
// |            when a grant is actually issued.                              |
// | Ports    : clk, rstb (async active-low), i_en (grant enable),            |
// |            i_req[NUM_REQ] requests, o_pick[NUM_REQ] one-hot candidate    |
// |            (ignores i_en), o_gnt[NUM_REQ] one-hot grant.                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module arf104b256e1r1w0cbbehcaa4acw_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               i_en,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_pick,
  output logic [NUM_REQ-1:0] o_gnt
);

  localparam int                 c_ptr_w   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [c_ptr_w-1:0] c_ptr_max = c_ptr_w'(NUM_REQ - 1);

  logic [c_ptr_w-1:0] r_ptr;
  logic [c_ptr_w-1:0] w_idx;
  logic [c_ptr_w-1:0] w_win;
  logic [c_ptr_w-1:0] w_nxt;
  logic               w_found;

  // The candidate is exposed separately from the grant so the parent can
  // look at the contender's address without a loop through i_en.
  always_comb begin
    o_pick  = '0;
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = c_ptr_w'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        o_pick[w_idx] = 1'b1;
        w_win         = w_idx;
        w_found       = 1'b1;
      end
    end
  end

  assign o_gnt = {NUM_REQ{i_en}} & o_pick;
  assign w_nxt = (w_win == c_ptr_max) ? '0 : w_win + 1'b1;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_ptr <= '0;
    end else if (|o_gnt) begin
      r_ptr <= w_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/arf104b256e1r1w0cbbehcaa4acw_port_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : arf104b256e1r1w0cbbehcaa4acw_port_sched                       |
// | Purpose  : Sequencer/arbiter for the 104b x 256 1R1W register file.      |
// |            Zero-fills the array after reset (INIT), then round-robin     |
// |            shares the write and read ports (RUN). init_start drains the  |
// |            read response pipe (DRAIN) and re-runs INIT.                  |
// | Ports    : clk, rstb (async active-low), init_start, init_done,          |
// |            wr_vld/wr_addr/wr_data/wr_rdy, rd_vld/rd_addr/rd_rdy,          |
// |            rsp_vld/rsp_id/rsp_data, arf_wr_en/arf_wr_addr/arf_wr_data,   |
// |            arf_rd_en/arf_rd_addr/arf_rd_data. arf_*_en double as the     |
// |            array clock-gate enables.                                     |
// | Options  : ARF104B256E1R1W0CBBEHCAA4ACW_PORT_SCHED_RAW_BYPASS_EN -        |
// |            same-address read/write both granted, read returns the new    |
// |            write data. Undefined: read stalls one cycle behind write.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module arf104b256e1r1w0cbbehcaa4acw_port_sched
  import arf104b256e1r1w0cbbehcaa4acw_port_sched_pkg::*;
#(
  parameter int NUM_REQ = c_num_req,
  parameter int ADDR_W  = c_addr_w,
  parameter int DEPTH   = c_depth,
  parameter int DATA_W  = c_data_w,
  parameter int RD_LAT  = c_rd_lat
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       init_start,
  output logic                       init_done,
  input  logic [NUM_REQ-1:0]         wr_vld,
  input  logic [NUM_REQ*ADDR_W-1:0]  wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  wr_data,
  output logic [NUM_REQ-1:0]         wr_rdy,
  input  logic [NUM_REQ-1:0]         rd_vld,
  input  logic [NUM_REQ*ADDR_W-1:0]  rd_addr,
  output logic [NUM_REQ-1:0]         rd_rdy,
  output logic                       rsp_vld,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       arf_wr_en,
  output logic [ADDR_W-1:0]          arf_wr_addr,
  output logic [DATA_W-1:0]          arf_wr_data,
  output logic                       arf_rd_en,
  output logic [ADDR_W-1:0]          arf_rd_addr,
  input  logic [DATA_W-1:0]          arf_rd_data
);

  localparam int                c_id_w = $clog2(NUM_REQ);
  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  rsp_ent_t          r_pipe [RD_LAT];

  logic               w_run;
  logic               w_init;
  logic [NUM_REQ-1:0] w_wr_req;
  logic [NUM_REQ-1:0] w_wr_pick;
  logic [NUM_REQ-1:0] w_wr_gnt;
  logic [NUM_REQ-1:0] w_rd_pick;
  logic [NUM_REQ-1:0] w_rd_gnt;
  logic [ADDR_W-1:0]  w_wr_addr_sel;
  logic [DATA_W-1:0]  w_wr_data_sel;
  logic [ADDR_W-1:0]  w_rd_addr_sel;
  logic               w_coll;
  logic               w_rd_ok;
  logic               w_pipe_busy;
  rsp_ent_t           w_pipe_in;

  assign w_run  = (r_state == RUN);
  assign w_init = (r_state == INIT);

  // Address/data of the current candidates (one-hot OR mux).
  always_comb begin
    w_wr_addr_sel = '0;
    w_wr_data_sel = '0;
    w_rd_addr_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_wr_pick[i]) begin
        w_wr_addr_sel = w_wr_addr_sel | wr_addr[i*ADDR_W +: ADDR_W];
        w_wr_data_sel = w_wr_data_sel | wr_data[i*DATA_W +: DATA_W];
      end
      if (w_rd_pick[i]) begin
        w_rd_addr_sel = w_rd_addr_sel | rd_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign w_coll = (|w_wr_pick) && (|w_rd_pick) && (w_wr_addr_sel == w_rd_addr_sel);

`ifdef ARF104B256E1R1W0CBBEHCAA4ACW_PORT_SCHED_RAW_BYPASS_EN
  assign w_wr_req = wr_vld;
  assign w_rd_ok  = w_run;
`else
  logic              r_stall;
  logic [ADDR_W-1:0] r_stall_addr;

  // A stalled read owns its address: writes to it wait until the read goes.
  always_comb begin
    w_wr_req = wr_vld;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_stall && (wr_addr[i*ADDR_W +: ADDR_W] == r_stall_addr)) w_wr_req[i] = 1'b0;
    end
  end

  assign w_rd_ok = w_run && !w_coll;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_stall      <= 1'b0;
      r_stall_addr <= '0;
    end else if (|w_rd_gnt) begin
      r_stall <= 1'b0;
    end else if (w_run && w_coll) begin
      r_stall      <= 1'b1;
      r_stall_addr <= w_rd_addr_sel;
    end
  end
`endif

  arf104b256e1r1w0cbbehcaa4acw_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_wr_arb (
    .clk    (clk),
    .rstb   (rstb),
    .i_en   (w_run),
    .i_req  (w_wr_req),
    .o_pick (w_wr_pick),
    .o_gnt  (w_wr_gnt)
  );

  arf104b256e1r1w0cbbehcaa4acw_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_rd_arb (
    .clk    (clk),
    .rstb   (rstb),
    .i_en   (w_rd_ok),
    .i_req  (rd_vld),
    .o_pick (w_rd_pick),
    .o_gnt  (w_rd_gnt)
  );

  always_comb begin
    w_pipe_in     = '0;
    w_pipe_in.vld = |w_rd_gnt;
    w_pipe_in.id  = c_rsp_id_w'(onehot_idx(8'(w_rd_gnt)));
`ifdef ARF104B256E1R1W0CBBEHCAA4ACW_PORT_SCHED_RAW_BYPASS_EN
    if (w_coll && (|w_rd_gnt)) begin
      w_pipe_in.byp      = 1'b1;
      w_pipe_in.byp_data = c_data_w'(w_wr_data_sel);
    end
`endif
  end

  // DRAIN may leave once only the final stage is occupied: that entry is
  // delivered this cycle and nothing follows it.
  always_comb begin
    w_pipe_busy = 1'b0;
    for (int k = 0; k < RD_LAT - 1; k++) begin
      w_pipe_busy = w_pipe_busy | r_pipe[k].vld;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= INIT;
      r_cnt   <= '0;
      for (int k = 0; k < RD_LAT; k++) r_pipe[k] <= '0;
    end else begin
      case (r_state)
        INIT: begin
          if (r_cnt == c_last) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RUN: begin
          if (init_start) r_state <= DRAIN;
        end
        DRAIN: begin
          if (!w_pipe_busy) begin
            r_state <= INIT;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= INIT;
          r_cnt   <= '0;
        end
      endcase
      r_pipe[0] <= w_pipe_in;
      for (int k = 1; k < RD_LAT; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  assign init_done = w_run;
  assign wr_rdy    = w_wr_gnt;
  assign rd_rdy    = w_rd_gnt;

  // INIT writes are held off while rstb is low so the array sees no enable
  // during reset.
  assign arf_wr_en   = (w_init && rstb) || (|w_wr_gnt);
  assign arf_wr_addr = w_init ? r_cnt : ((|w_wr_gnt) ? w_wr_addr_sel : '0);
  assign arf_wr_data = (!w_init && (|w_wr_gnt)) ? w_wr_data_sel : '0;
  assign arf_rd_en   = |w_rd_gnt;
  assign arf_rd_addr = (|w_rd_gnt) ? w_rd_addr_sel : '0;

  assign rsp_vld  = r_pipe[RD_LAT-1].vld;
  assign rsp_id   = c_id_w'(r_pipe[RD_LAT-1].id);
  assign rsp_data = r_pipe[RD_LAT-1].byp ? DATA_W'(r_pipe[RD_LAT-1].byp_data) : arf_rd_data;

endmodule
`default_nettype wire
